// File: rtl/regfile_mp.sv
// regfile_mp: NUM_RD registered read ports, one write port, r0 hardwired to 0.
// Option macro REGFILE_BYPASS_EN forwards same-cycle write data to matching reads.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    output logic                     busy,
    input  logic                     rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     rd_valid,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic              open;
    logic              rd_accept;
    logic              wr_accept;
    logic [DATA_W-1:0] rd_next [NUM_RD];
    logic [DATA_W-1:0] rd_q    [NUM_RD];

    assign busy      = (state == CLEAR);
    assign open      = (state == READY) && !clear && !reset;
    assign rd_accept = open && rd_en;
    assign wr_accept = open && wr_en && (wr_addr != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            CLEAR: begin
                cnt_next = cnt + CNT_ONE;
                if (cnt == CNT_LAST) begin
                    state_next = READY;
                    cnt_next   = '0;
                end
            end
            READY: begin
                if (clear) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
        endcase
    end

    // Single write port shared by the clear engine and the writeback path.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt[ADDR_W-1:0];
            mem_wdata = '0;
        end else if (wr_accept) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_next[k] = mem[rd_addr[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
            if (wr_accept && (wr_addr == rd_addr[k*ADDR_W +: ADDR_W])) begin
                rd_next[k] = wr_data;
            end
`endif
            if (rd_addr[k*ADDR_W +: ADDR_W] == '0) begin
                rd_next[k] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            for (int k = 0; k < NUM_RD; k++) begin
                rd_q[k] <= '0;
            end
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) begin
                for (int k = 0; k < NUM_RD; k++) begin
                    rd_q[k] <= rd_next[k];
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_out
        assign rd_data[k*DATA_W +: DATA_W] = rd_q[k];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: directed plan followed by random traffic.
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 32;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     clear;
    logic                     busy;
    logic                     rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     rd_valid;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;

    int checks   = 0;
    int failures = 0;

    logic [NUM_RD*DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0]        model_mem [DEPTH];
    int                       clear_left;

    regfile_mp #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NUM_RD(NUM_RD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .busy    (busy),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    // Monitor: pops the scoreboard on every valid, else checks data hold.
    logic [NUM_RD*DATA_W-1:0] last_data = '0;
    always @(posedge clk) begin
        #1;
        if (reset) begin
            checks++;
            if (rd_valid !== 1'b0 || rd_data !== '0) begin
                failures++;
                $display("FAIL reset_out valid=%b data=%h want valid=0 data=0",
                         rd_valid, rd_data);
            end
            last_data = '0;
        end else if (rd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid data=%h want no valid", rd_data);
            end else begin
                logic [NUM_RD*DATA_W-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    failures++;
                    $display("FAIL read_data got=%h want=%h", rd_data, e);
                end
            end
            last_data = rd_data;
        end else begin
            checks++;
            if (rd_valid !== 1'b0 || rd_data !== last_data) begin
                failures++;
                $display("FAIL hold valid=%b data=%h want valid=0 data=%h",
                         rd_valid, rd_data, last_data);
            end
        end
    end

    function automatic void model_zero();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endfunction

    // One clock: drive at negedge, update the model, check busy after the edge.
    task automatic cyc(input bit rst, input bit clr, input bit re,
                       input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                       input bit we, input logic [ADDR_W-1:0] wa,
                       input logic [DATA_W-1:0] wd);
        logic [ADDR_W-1:0] ra [NUM_RD];
        logic [NUM_RD*DATA_W-1:0] e;
        @(negedge clk);
        reset   = rst;
        clear   = clr;
        rd_en   = re;
        rd_addr = {a1, a0};
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        ra[0] = a0;
        ra[1] = a1;
        if (rst) begin
            clear_left = DEPTH;
            model_zero();
        end else if (clear_left > 0) begin
            clear_left--;
        end else if (clr) begin
            clear_left = DEPTH;
            model_zero();
        end else begin
            if (re) begin
                e = '0;
                for (int k = 0; k < NUM_RD; k++) begin
                    logic [DATA_W-1:0] v;
                    v = (ra[k] == 0) ? '0 : model_mem[ra[k]];
`ifdef REGFILE_BYPASS_EN
                    if (we && wa == ra[k] && ra[k] != 0) v = wd;
`endif
                    e[k*DATA_W +: DATA_W] = v;
                end
                exp_q.push_back(e);
            end
            if (we && wa != 0) model_mem[wa] = wd;
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== (clear_left > 0)) begin
            failures++;
            $display("FAIL busy got=%b want=%b", busy, clear_left > 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        cyc(0, 0, 1, a0, a1, 0, 0, 0);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
        cyc(0, 0, 0, 0, 0, 1, wa, wd);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) begin
            rd(ADDR_W'(i), ADDR_W'(DEPTH - 1 - i));
        end
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; rd_en = 1'b0; rd_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        clear_left = DEPTH;
        model_zero();

        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        idle(DEPTH);
        read_all();

        wr(5, 32'hDEADBEEF);
        rd(5, 0);
        wr(0, 32'hFFFFFFFF);
        rd(0, 0);

        wr(7, 32'h00000001);
        cyc(0, 0, 1, 7, 7, 1, 7, 32'h12345678);
        rd(7, 7);

        wr(3, 32'hA5A5A5A5);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 3, 4, 1, 4, 32'h1);
        idle(DEPTH - 1);
        rd(3, 4);

        wr(9, 32'h0BADF00D);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        idle(10);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        idle(DEPTH);
        read_all();

        for (int i = 0; i < 600; i++) begin
            bit rst_r, clr_r, re_r, we_r;
            logic [ADDR_W-1:0] a0, a1, wa;
            rst_r = ($urandom_range(0, 299) == 0);
            clr_r = ($urandom_range(0, 79) == 0);
            re_r  = $urandom_range(0, 2) != 0;
            we_r  = $urandom_range(0, 1) != 0;
            a0 = ADDR_W'($urandom_range(0, 7));
            a1 = ADDR_W'($urandom_range(0, DEPTH - 1));
            wa = ($urandom_range(0, 1) != 0) ? a0 : ADDR_W'($urandom_range(0, 7));
            cyc(rst_r, clr_r, re_r, a0, a1, we_r, wa, DATA_W'($urandom));
        end
        idle(DEPTH + 2);
        read_all();
        idle(3);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_valid pending=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the CPU datapath, replacing the single-cycle combinational register array. Provides NUM_RD registered read ports and one synchronous write port. Register 0 is hardwired to zero. Storage is cleared by a sequential clear engine, one entry per cycle, so the array can map to RAM. The decode stage reads operands here, and the writeback stage writes results here.

## Interface
Parameters:
- DATA_W, 32, data width of each register
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-high
- clear  input  1  soft-clear request pulse; honoured only when busy=0
- busy  output  1  clear engine active; reads and writes not accepted
- rd_en  input  1  read request, all ports together
- rd_addr  input  NUM_RD*ADDR_W  read addresses; port k at [k*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  read data; port k at [k*DATA_W +: DATA_W]
- rd_valid  output  1  rd_data holds the result of a read accepted on the previous cycle
- wr_en  input  1  write request
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data

## Operation
- FSM states: CLEAR and READY.
- reset high → state CLEAR, clear counter cnt=0, busy=1, rd_valid=0, rd_data=0.
- CLEAR:
  - Each cycle writes 0 to entry cnt, then cnt increments.
  - When cnt==DEPTH-1 is written, the next state is READY.
  - wr_en, rd_en and clear are ignored. rd_valid stays 0.
- READY:
  - clear=1 → state CLEAR, cnt=0. Any wr_en or rd_en in that same cycle is ignored.
  - clear=0 → reads and writes are serviced.
- Write: if wr_en=1 and wr_addr!=0, the entry is updated at the clock edge. Writes to address 0 are discarded.
- Read:
  - rd_en=1 in READY samples every port's address.
  - rd_data for each port is registered at the edge, and rd_valid=1 for the following cycle.
  - Address 0 always returns 0.
  - rd_en=0 → rd_valid=0 next cycle, and rd_data holds its previous value.
- Same-cycle write and read of the same nonzero address: behaviour is set by REGFILE_BYPASS_EN (see Configuration).
- Multiple ports reading the same address return identical data.
- reset mid-CLEAR restarts cnt at 0. reset mid-READY discards the in-flight read (rd_valid=0) and starts a full clear.
- Addresses are unsigned. cnt is ADDR_W+1 bits wide and never wraps past DEPTH-1.

## Timing
- Reset values: busy=1, rd_valid=0, rd_data=0 on all ports.
- Clear duration: busy stays high for exactly DEPTH cycles after the last reset-high cycle, or after the clear-accept cycle. With defaults this is 32 cycles.
- First read or write is accepted in the first cycle with busy=0.
- Read latency: 1 cycle, from rd_en sampled to rd_data/rd_valid.
- Write latency: a write at edge N is visible to a read sampled at edge N+1 or later.
- No backpressure. Every request in READY with clear=0 completes.

## Configuration
- REGFILE_BYPASS_EN defined: a same-cycle write and read of the same nonzero address returns the new wr_data.
- REGFILE_BYPASS_EN undefined: that read returns the pre-write value. A write-through-reads-new result requires an extra cycle.
- Address 0 always reads 0 in both builds.

## Test plan
- Reset pulse of 1 cycle, then idle → busy=1 for exactly 32 cycles. A subsequent read of all 32 addresses on both ports returns 0x00000000 with rd_valid=1.
- Write r5=0xDEADBEEF. Next cycle, read port0=r5, port1=r0 → one cycle later rd_data0=0xDEADBEEF, rd_data1=0, rd_valid=1.
- Write r0=0xFFFFFFFF, then read r0 on both ports → 0x00000000.
- Preload r7=0x00000001. Write r7=0x12345678 while reading r7 in the same cycle → 0x12345678 with REGFILE_BYPASS_EN, 0x00000001 without. Either way a read on the next cycle returns 0x12345678.
- Write r3=0xA5A5A5A5, pulse clear, then attempt a write of r4=0x1 while busy → busy high 32 cycles, rd_valid=0 throughout. Afterwards r3=0 and r4=0.
- Assert reset at cnt=10 of a clear → cnt restarts at 0. busy falls exactly 32 cycles after reset deasserts, and all entries read 0.
